// File: rtl/counter_cmd_arb_pkg.sv
// Shared types for the counter command arbiter: opcodes, default widths and
// the stage-1 command record.
package counter_arb_pkg;

   localparam int DW_DEFAULT      = 8;
   localparam int DELTA_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      OP_READ = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } op_e;

   // id is wide enough for the largest supported requester count (8)
   typedef struct packed {
      op_e                   op;
      logic [DW_DEFAULT-1:0] data;
      logic [2:0]            id;
      logic                  err;
   } cmd_t;

endpackage

// File: rtl/counter_cmd_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// priority pointer; the pointer moves past the winner whenever advance is high.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          found;
   int            idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (advance && found)
         ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/counter_cmd_arb.sv
// Round-robin command arbiter and 2-stage sequencer in front of the shared
// up/down counter; returns one tagged response per accepted command.
module counter_cmd_arb
   import counter_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = DW_DEFAULT,
   parameter int DELTA_W = DELTA_W_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [2*N_REQ-1:0]         req_op,
   input  logic [DW*N_REQ-1:0]        req_data,
   output logic                       cnt_preload,
   output logic                       cnt_up_dn,
   output logic [DELTA_W-1:0]         cnt_delta,
   output logic [DW-1:0]              cnt_pl_data,
   input  logic [DW-1:0]              cnt_q,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [DW-1:0]              rsp_q,
   output logic                       rsp_wrap,
   output logic                       rsp_err
);

   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0] gnt;
   logic             acc;
   logic [2:1]       vld_pipe;
   cmd_t             s1, cmd_nxt;
   logic [1:0]       sel_op;
   logic [DW-1:0]    sel_data;
   logic [2:0]       sel_id;
   logic [DW:0]      inc_sum;
   logic             wrap;

   // No grant can be issued while reset is high
   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid & {N_REQ{~reset}}),
      .advance (acc),
      .gnt     (gnt)
   );

   assign req_ready = gnt;
   assign acc       = |gnt;

   always_comb begin
      sel_op   = '0;
      sel_data = '0;
      sel_id   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_op   = req_op[2*i +: 2];
            sel_data = req_data[DW*i +: DW];
            sel_id   = 3'(i);
         end
      end
   end

   always_comb begin
      cmd_nxt      = '0;
      cmd_nxt.op   = op_e'(sel_op);
      cmd_nxt.data = DW_DEFAULT'(sel_data);
      cmd_nxt.id   = sel_id;
      cmd_nxt.err  = (cmd_nxt.op == OP_INC || cmd_nxt.op == OP_DEC) &&
                     (|sel_data[DW-1:DELTA_W]);
   end

   // Counter controls decode straight from the stage-1 register; an empty or
   // rejected slot always presents the hold encoding.
   always_comb begin
      cnt_preload = 1'b0;
      cnt_up_dn   = 1'b1;
      cnt_delta   = '0;
      cnt_pl_data = '0;
      if (vld_pipe[1] && !s1.err) begin
         case (s1.op)
            OP_LOAD: begin
               cnt_preload = 1'b1;
               cnt_pl_data = DW'(s1.data);
            end
            OP_INC:  cnt_delta = s1.data[DELTA_W-1:0];
            OP_DEC: begin
               cnt_up_dn = 1'b0;
               cnt_delta = s1.data[DELTA_W-1:0];
            end
            default: ;
         endcase
      end
   end

   // cnt_q here is still the pre-command value
   assign inc_sum = {1'b0, cnt_q} + (DW+1)'(cnt_delta);
   assign wrap    = vld_pipe[1] && !s1.err &&
                    ((s1.op == OP_INC && inc_sum[DW]) ||
                     (s1.op == OP_DEC && cnt_q < DW'(cnt_delta)));

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         s1       <= '0;
         rsp_id   <= '0;
         rsp_wrap <= 1'b0;
         rsp_err  <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[1], acc};
         s1       <= acc ? cmd_nxt : '0;
         rsp_id   <= IW'(s1.id);
         rsp_wrap <= wrap;
         rsp_err  <= vld_pipe[1] & s1.err;
      end
   end

   assign rsp_valid = vld_pipe[2];
   assign rsp_q     = cnt_q;

endmodule

// File: tb/tb_counter_cmd_arb.sv
// Randomized bench for counter_cmd_arb: a behavioural counter plus a
// transaction-level model of arbitration and expected responses.
module tb_counter_cmd_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int DL = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid, req_ready;
   logic [2*N-1:0]    req_op;
   logic [DW*N-1:0]   req_data;
   logic              cnt_preload, cnt_up_dn;
   logic [DL-1:0]     cnt_delta;
   logic [DW-1:0]     cnt_pl_data, cnt_q;
   logic              rsp_valid, rsp_wrap, rsp_err;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_q;

   counter_cmd_arb #(.N_REQ(N), .DW(DW), .DELTA_W(DL)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_data(req_data), .cnt_preload(cnt_preload),
      .cnt_up_dn(cnt_up_dn), .cnt_delta(cnt_delta), .cnt_pl_data(cnt_pl_data),
      .cnt_q(cnt_q), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
      .rsp_wrap(rsp_wrap), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // the shared counter that the parent would instantiate
   always @(posedge clk) begin
      if (reset)            cnt_q <= '0;
      else if (cnt_preload) cnt_q <= cnt_pl_data;
      else if (cnt_up_dn)   cnt_q <= cnt_q + DW'(cnt_delta);
      else                  cnt_q <= cnt_q - DW'(cnt_delta);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int due;
      int id;
      int q;
      int wrap;
      int err;
   } exp_t;

   exp_t         mq[$];
   int           cyc = 0;
   int           m_cnt = 0;
   int           m_ptr = 0;
   bit           last_acc = 0;
   logic [N-1:0] acc_mask = '0;

   // Reference model: grants, counter value and responses by transaction
   always @(negedge clk) begin
      logic [N-1:0] exp_g, acc;
      int j, id, op, d, pre, s;
      exp_t e;
      if (reset) begin
         chk("rdy_in_reset", 32'(req_ready), 0);
         mq.delete();
         m_cnt = 0; m_ptr = 0; last_acc = 0; acc_mask = '0;
      end else begin
         exp_g = '0;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (exp_g == 0 && req_valid[j]) exp_g[j] = 1'b1;
         end
         chk("grant", 32'(req_ready), 32'(exp_g));
         if (!last_acc) begin
            chk("idle_preload", 32'(cnt_preload), 0);
            chk("idle_delta", 32'(cnt_delta), 0);
         end
         if (mq.size() > 0 && mq[0].due == cyc) begin
            e = mq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), e.id);
            chk("rsp_q", 32'(rsp_q), e.q);
            chk("rsp_wrap", 32'(rsp_wrap), e.wrap);
            chk("rsp_err", 32'(rsp_err), e.err);
         end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
         end
         acc = req_valid & req_ready;
         acc_mask = acc;
         if (acc != 0) begin
            id = 0;
            for (int k = 0; k < N; k++) if (acc[k]) id = k;
            op  = int'(req_op[2*id +: 2]);
            d   = int'(req_data[DW*id +: DW]);
            pre = m_cnt;
            e.due = cyc + 2; e.id = id; e.wrap = 0; e.err = 0;
            if (op == 1) m_cnt = d;
            else if (op >= 2 && d > 15) e.err = 1;
            else if (op == 2) begin
               s = pre + d; e.wrap = (s > 255); m_cnt = s % 256;
            end else if (op == 3) begin
               e.wrap = (pre < d); m_cnt = (pre - d + 256) % 256;
            end
            e.q = m_cnt;
            mq.push_back(e);
            m_ptr = (id + 1) % N;
         end
         last_acc = (acc != 0);
      end
      cyc++;
   end

   task automatic send(input int i, input int op, input int data);
      bit got;
      @(posedge clk); #1;
      req_valid[i] = 1'b1;
      req_op[2*i +: 2] = 2'(op);
      req_data[DW*i +: DW] = DW'(data);
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = '1; req_op = '0; req_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_preload", 32'(cnt_preload), 0);
      chk("rst_up_dn", 32'(cnt_up_dn), 1);
      chk("rst_delta", 32'(cnt_delta), 0);
      chk("rst_pl_data", 32'(cnt_pl_data), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_wrap", 32'(rsp_wrap), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      @(posedge clk); #1;
      reset = 1'b0; req_valid = '0;

      // LOAD 0x10 on req0 with stage-by-stage timing
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_op[1:0] = 2'd1; req_data[7:0] = 8'h10;
      @(negedge clk);
      chk("t_ready0", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_preload", 32'(cnt_preload), 1);
      chk("t1_pl_data", 32'(cnt_pl_data), 32'h10);
      @(negedge clk);
      chk("t2_rsp_valid", 32'(rsp_valid), 1);
      chk("t2_rsp_q", 32'(rsp_q), 32'h10);

      // wrap both directions
      send(0, 1, 8'hFD);
      send(1, 2, 5);
      send(1, 3, 3);

      // all requesters continuously, INC 1 from 0
      send(0, 1, 0);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1; req_op[2*i +: 2] = 2'd2; req_data[DW*i +: DW] = 8'd1;
      end
      repeat (9) @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;

      // oversized step is rejected
      send(2, 2, 8'h12);

      // idle hold after LOAD 0x55, then READ
      send(0, 1, 8'h55);
      @(negedge clk);
      repeat (10) begin
         @(negedge clk);
         chk("idle_cnt_q", 32'(cnt_q), 32'h55);
      end
      send(3, 0, 0);
      repeat (3) @(negedge clk);

      // reset right after an accept flushes the pipeline
      send(1, 2, 1);
      reset = 1'b1; req_valid = '1;
      @(negedge clk);
      @(negedge clk);
      chk("flush_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ptr_restart", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;

      // randomized traffic
      repeat (2000) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && (acc_mask[i] || $urandom_range(15) == 0))
               req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(2) == 0) begin
               req_valid[i] = 1'b1;
               req_op[2*i +: 2] = 2'($urandom_range(3));
               if (req_op[2*i +: 2] >= 2'd2 && $urandom_range(7) != 0)
                  req_data[DW*i +: DW] = DW'($urandom_range(15));
               else
                  req_data[DW*i +: DW] = DW'($urandom_range(255));
            end
         end
      end
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(negedge clk);
      chk("drain_empty", 32'(mq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/counter_cmd_arb.md
# counter_cmd_arb

Round-robin command arbiter and sequencer for the shared 8-bit up/down counter. Up to N_REQ requesters issue READ/LOAD/INC/DEC commands over valid/ready handshakes. The block grants one command per cycle and drives the counter's preload/up_dn/delta/pl_data controls. Each command gets a tagged response carrying the resulting count, a wrap flag and an error flag. It sits between the counter and its client logic, and is the only driver of the counter's control inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, counter width
- DELTA_W, 4, counter step width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester command valid
- req_ready  out  N_REQ  one-hot grant; command accepted when valid & ready
- req_op  in  2*N_REQ  per-requester opcode: 0 READ, 1 LOAD, 2 INC, 3 DEC
- req_data  in  DW*N_REQ  per-requester operand (load value, or step in low DELTA_W bits)
- cnt_preload  out  1  counter preload control
- cnt_up_dn  out  1  counter direction (1 = up)
- cnt_delta  out  DELTA_W  counter step
- cnt_pl_data  out  DW  counter preload value
- cnt_q  in  DW  counter current value
- rsp_valid  out  1  response valid (no backpressure)
- rsp_id  out  $clog2(N_REQ)  index of the requester being answered
- rsp_q  out  DW  counter value after the command
- rsp_wrap  out  1  INC/DEC crossed 0xFF↔0x00
- rsp_err  out  1  command rejected

## Operation
- Arbitration:
  - req_ready is combinational from req_valid and a registered priority pointer.
  - The first valid requester at or after the pointer (modulo N_REQ) is granted. At most one bit of req_ready is high.
  - On grant, the pointer moves to grant+1. With no grant, the pointer holds.
- Requesters hold req_op/req_data stable while valid and not ready. Dropping valid before ready is legal; no command is issued.
- Stage 1 (cycle after grant): registered command drives the counter.
  - READ: preload=0, up_dn=1, delta=0 (hold).
  - LOAD: preload=1, pl_data=req_data.
  - INC: up_dn=1, delta=req_data[DELTA_W-1:0].
  - DEC: up_dn=0, delta=req_data[DELTA_W-1:0].
  - Error case: INC/DEC with req_data[DW-1:DELTA_W] ≠ 0 is accepted but drives hold, and rsp_err=1.
  - Idle (no command in stage 1): hold encoding. The counter must never move without a command.
- Wrap, computed in stage 1 from cnt_q (the pre-command value):
  - INC: wrap when cnt_q + delta > 2^DW−1.
  - DEC: wrap when cnt_q < delta.
  - Always 0 for READ/LOAD/err.
- Stage 2: rsp_valid=1, and rsp_id/rsp_wrap/rsp_err come from registers. rsp_q is cnt_q passed through combinationally, i.e. the post-command value.
- Arithmetic is modulo 2^DW. The counter wraps and this block only reports it.
- Reset:
  - Registered outputs: req pointer 0, cnt_preload 0, cnt_up_dn 1, cnt_delta 0, cnt_pl_data 0, rsp_valid 0, rsp_id 0, rsp_wrap 0, rsp_err 0.
  - req_ready is 0 while reset is high.
  - Reset asserted mid-operation flushes both stages. No response is ever produced for a command accepted before or during reset.
  - The counter is reset by the same reset at the parent level.

## Timing
- Command accepted in cycle T.
- Counter controls driven in T+1; the counter updates at the T+1→T+2 edge.
- rsp_valid, with the final rsp_q, in T+2. Latency is fixed at 2 cycles.
- Throughput is one command per cycle. Back-to-back commands are correct because cnt_q in stage 1 always reflects every earlier command.
- Responses come in grant order, one per accepted command, with no gaps or duplicates.
- rsp_q is valid only while rsp_valid=1.

## Structure
- Package counter_arb_pkg:
  - op_e enum (OP_READ, OP_LOAD, OP_INC, OP_DEC)
  - DW / DELTA_W defaults
  - packed stage-1 command struct (op, data, id, err)
- Sub-module rr_arbiter: parameter N; inputs req[N] and advance; outputs one-hot gnt[N]; owns the pointer. Reusable elsewhere.
- The pipeline registers, opcode decode and wrap logic stay in counter_cmd_arb. The counter is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req0 LOAD 0x10 → req_ready[0]=1 in T; cnt_preload=1, cnt_pl_data=0x10 in T+1; rsp_valid, rsp_id=0, rsp_q=0x10, wrap=0, err=0 in T+2.
- After LOAD 0xFD, req1 INC 5 → rsp_q=0x02, rsp_wrap=1, rsp_id=1. Then DEC 3 → rsp_q=0xFF, rsp_wrap=1.
- All four requesters valid continuously with INC 1 from 0 → grants 0,1,2,3,0,… on consecutive cycles; responses every cycle with rsp_q=1,2,3,4,5 and rsp_id matching.
- req2 INC with data 0x12 → accepted; counter controls hold; rsp_err=1, rsp_q unchanged, rsp_wrap=0.
- No requests for 10 cycles after LOAD 0x55 → cnt_preload=0, cnt_delta=0 throughout; cnt_q stays 0x55; rsp_valid stays 0. READ then returns 0x55.
- Accept INC 1 in T, assert reset in T+1 → no rsp_valid in T+2. After reset, req_ready=0 while reset is high and the pointer restarts at requester 0.
